// File: rtl/risc_v_mike_pkg.sv
// Shared definitions for the risc_v_mike GPIO controller: register offsets,
// register selector enum and small address-decode helpers.
package risc_v_mike_pkg;

  localparam logic [5:0] OFF_DATA_IN    = 6'h00;
  localparam logic [5:0] OFF_DATA_OUT   = 6'h04;
  localparam logic [5:0] OFF_DIR        = 6'h08;
  localparam logic [5:0] OFF_IRQ_EN     = 6'h0C;
  localparam logic [5:0] OFF_IRQ_EDGE   = 6'h10;
  localparam logic [5:0] OFF_IRQ_STATUS = 6'h14;
  localparam logic [5:0] OFF_OUT_SET    = 6'h18;
  localparam logic [5:0] OFF_OUT_CLR    = 6'h1C;

  typedef enum logic [2:0] {
    REG_DATA_IN    = 3'd0,
    REG_DATA_OUT   = 3'd1,
    REG_DIR        = 3'd2,
    REG_IRQ_EN     = 3'd3,
    REG_IRQ_EDGE   = 3'd4,
    REG_IRQ_STATUS = 3'd5,
    REG_OUT_SET    = 3'd6,
    REG_OUT_CLR    = 3'd7
  } t_gpio_reg;

  // Word-aligned and inside the eight-register map.
  function automatic logic offset_mapped(input logic [5:0] off);
    return (off[1:0] == 2'b00) && (off <= OFF_OUT_CLR);
  endfunction

  function automatic t_gpio_reg offset_to_reg(input logic [5:0] off);
    return t_gpio_reg'(off[4:2]);
  endfunction

endpackage

// File: rtl/risc_v_mike_sync_chain.sv
// Multi-stage flop synchroniser for asynchronous pad inputs; output is the
// last stage, DEPTH cycles behind the pad.
module risc_v_mike_sync_chain #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  // Shift pad samples through the chain; cleared while rst is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/risc_v_mike_gpio_ctrl.sv
// Memory-mapped GPIO controller: data/direction registers, set/clear aliases,
// synchronised inputs with per-pin edge interrupts and a single-cycle bus.
module risc_v_mike_gpio_ctrl
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned GPIO_W      = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mmio_req,
  input  logic              mmio_we,
  input  logic [31:0]       mmio_addr,
  input  logic [31:0]       mmio_wdata,
  output logic [31:0]       mmio_rdata,
  output logic              mmio_ack,
  output logic              mmio_err,
  input  logic [GPIO_W-1:0] gpio_port_in,
  output logic [GPIO_W-1:0] gpio_port_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              gpio_irq
);

  // Edge detection stays off until the chain and its delayed copy hold real pad data.
  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [GPIO_W-1:0] data_out_q, data_out_d;
  logic [GPIO_W-1:0] dir_q, dir_d;
  logic [GPIO_W-1:0] irq_en_q, irq_en_d;
  logic [GPIO_W-1:0] irq_edge_q, irq_edge_d;
  logic [GPIO_W-1:0] irq_status_q, irq_status_d;
  logic [GPIO_W-1:0] prev_q;
  logic [2:0]        warm_q, warm_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              irq_q, irq_d;

  logic [GPIO_W-1:0] sync_s, wdata_s, rd_val_s, w1c_s, edge_hit_s;
  logic              in_win_s, acc_s, mapped_s, edge_en_s;
  t_gpio_reg         reg_s;
  logic              unused_wdata_s;

  risc_v_mike_sync_chain #(
    .W     (GPIO_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (gpio_port_in),
    .q_o (sync_s)
  );

  assign in_win_s       = (mmio_addr[31:6] == BASE_ADDR[31:6]);
  assign acc_s          = mmio_req & in_win_s;
  assign mapped_s       = offset_mapped(mmio_addr[5:0]);
  assign reg_s          = offset_to_reg(mmio_addr[5:0]);
  assign wdata_s        = mmio_wdata[GPIO_W-1:0];
  assign unused_wdata_s = ^mmio_wdata;
  assign edge_en_s      = (warm_q == WARM_DONE);

  // Selected edge per pin: rising when IRQ_EDGE=0, falling when IRQ_EDGE=1.
  always_comb begin
    edge_hit_s = '0;
    warm_d     = warm_q;
    if (edge_en_s) begin
      edge_hit_s = (~irq_edge_q & sync_s & ~prev_q) | (irq_edge_q & ~sync_s & prev_q);
    end else begin
      warm_d = warm_q + 3'd1;
    end
  end

  // Bus decode and register next-state; edge set is OR-ed after W1C so set wins.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    irq_edge_d = irq_edge_q;
    w1c_s      = '0;
    rd_val_s   = '0;
    rdata_d    = 32'h0000_0000;
    ack_d      = acc_s;
    err_d      = 1'b0;
    if (acc_s && !mapped_s) begin
      err_d = 1'b1;
    end else if (acc_s && mmio_we) begin
      case (reg_s)
        REG_DATA_OUT:   data_out_d = wdata_s;
        REG_DIR:        dir_d      = wdata_s;
        REG_IRQ_EN:     irq_en_d   = wdata_s;
        REG_IRQ_EDGE:   irq_edge_d = wdata_s;
        REG_IRQ_STATUS: w1c_s      = wdata_s;
        REG_OUT_SET:    data_out_d = data_out_q | wdata_s;
        REG_OUT_CLR:    data_out_d = data_out_q & ~wdata_s;
        default:        data_out_d = data_out_q;
      endcase
    end else if (acc_s) begin
      case (reg_s)
        REG_DATA_IN:    rd_val_s = sync_s;
        REG_DATA_OUT:   rd_val_s = data_out_q;
        REG_DIR:        rd_val_s = dir_q;
        REG_IRQ_EN:     rd_val_s = irq_en_q;
        REG_IRQ_EDGE:   rd_val_s = irq_edge_q;
        REG_IRQ_STATUS: rd_val_s = irq_status_q;
        default:        rd_val_s = '0;
      endcase
      rdata_d[GPIO_W-1:0] = rd_val_s;
    end else begin
      ack_d = 1'b0;
    end
    irq_status_d = (irq_status_q & ~w1c_s) | edge_hit_s;
    irq_d        = |(irq_status_q & irq_en_q);
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_q   <= '0;
      dir_q        <= '0;
      irq_en_q     <= '0;
      irq_edge_q   <= '0;
      irq_status_q <= '0;
      prev_q       <= '0;
      warm_q       <= 3'd0;
      rdata_q      <= 32'h0000_0000;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      irq_en_q     <= irq_en_d;
      irq_edge_q   <= irq_edge_d;
      irq_status_q <= irq_status_d;
      prev_q       <= sync_s;
      warm_q       <= warm_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      irq_q        <= irq_d;
    end
  end

  assign mmio_rdata    = rdata_q;
  assign mmio_ack      = ack_q;
  assign mmio_err      = err_q;
  assign gpio_port_out = data_out_q;
  assign gpio_oe       = dir_q;
  assign gpio_irq      = irq_q;

endmodule

// File: tb/tb_risc_v_mike_gpio_ctrl.sv
// Directed bench for risc_v_mike_gpio_ctrl: a back-to-back vector table plus
// hand sequences for reset, interrupt timing, W1C/edge collision and reset mid-burst.
module tb_risc_v_mike_gpio_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_req;
  logic        mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        mmio_ack;
  logic        mmio_err;
  logic [7:0]  gpio_port_in;
  logic [7:0]  gpio_port_out;
  logic [7:0]  gpio_oe;
  logic        gpio_irq;

  int checks = 0;
  int errors = 0;

  risc_v_mike_gpio_ctrl #(
    .GPIO_W      (8),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mmio_req      (mmio_req),
    .mmio_we       (mmio_we),
    .mmio_addr     (mmio_addr),
    .mmio_wdata    (mmio_wdata),
    .mmio_rdata    (mmio_rdata),
    .mmio_ack      (mmio_ack),
    .mmio_err      (mmio_err),
    .gpio_port_in  (gpio_port_in),
    .gpio_port_out (gpio_port_out),
    .gpio_oe       (gpio_oe),
    .gpio_irq      (gpio_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  out;
    logic [7:0]  oe;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; request is sampled on the next posedge, response read at the following negedge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic ak, output logic er);
    mmio_req   = 1'b1;
    mmio_we    = we;
    mmio_addr  = addr;
    mmio_wdata = wd;
    @(negedge clk);
    mmio_req = 1'b0;
    mmio_we  = 1'b0;
    rd = mmio_rdata;
    ak = mmio_ack;
    er = mmio_err;
  endtask

  task automatic rd_chk(input string name, input logic [5:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic ak, er;
    access(1'b0, BASE + {26'd0, off}, 32'h0, rd, ak, er);
    chk(name, {30'd0, ak, er, rd}, {30'd0, 1'b1, 1'b0, exp});
  endtask

  task automatic wr_chk(input string name, input logic [5:0] off, input logic [31:0] wd);
    logic [31:0] rd;
    logic ak, er;
    access(1'b1, BASE + {26'd0, off}, wd, rd, ak, er);
    chk(name, {30'd0, ak, er, rd}, {30'd0, 1'b1, 1'b0, 32'h0});
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, BASE + 32'h08, 32'h0000_00FF, 1'b1, 1'b0, 32'h0, 8'h00, 8'hFF};
    vecs[1]  = '{1'b1, 1'b1, BASE + 32'h04, 32'h0000_00A5, 1'b1, 1'b0, 32'h0, 8'hA5, 8'hFF};
    vecs[2]  = '{1'b1, 1'b0, BASE + 32'h04, 32'h0,         1'b1, 1'b0, 32'hA5, 8'hA5, 8'hFF};
    vecs[3]  = '{1'b1, 1'b1, BASE + 32'h18, 32'h0000_000F, 1'b1, 1'b0, 32'h0, 8'hAF, 8'hFF};
    vecs[4]  = '{1'b1, 1'b1, BASE + 32'h1C, 32'h0000_0081, 1'b1, 1'b0, 32'h0, 8'h2E, 8'hFF};
    vecs[5]  = '{1'b1, 1'b0, BASE + 32'h04, 32'h0,         1'b1, 1'b0, 32'h2E, 8'h2E, 8'hFF};
    vecs[6]  = '{1'b1, 1'b0, BASE + 32'h18, 32'h0,         1'b1, 1'b0, 32'h0, 8'h2E, 8'hFF};
    vecs[7]  = '{1'b1, 1'b0, BASE + 32'h02, 32'h0,         1'b1, 1'b1, 32'h0, 8'h2E, 8'hFF};
    vecs[8]  = '{1'b1, 1'b0, BASE + 32'h20, 32'h0,         1'b1, 1'b1, 32'h0, 8'h2E, 8'hFF};
    vecs[9]  = '{1'b1, 1'b1, BASE + 32'h06, 32'h0000_00FF, 1'b1, 1'b1, 32'h0, 8'h2E, 8'hFF};
    vecs[10] = '{1'b1, 1'b0, BASE + 32'h40, 32'h0,         1'b0, 1'b0, 32'h0, 8'h2E, 8'hFF};
    vecs[11] = '{1'b1, 1'b1, BASE + 32'h00, 32'h0000_00FF, 1'b1, 1'b0, 32'h0, 8'h2E, 8'hFF};
    vecs[12] = '{1'b1, 1'b0, BASE + 32'h00, 32'h0,         1'b1, 1'b0, 32'h0, 8'h2E, 8'hFF};
    vecs[13] = '{1'b0, 1'b1, BASE + 32'h04, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 8'h2E, 8'hFF};
    vecs[14] = '{1'b1, 1'b0, BASE + 32'h08, 32'h0,         1'b1, 1'b0, 32'hFF, 8'h2E, 8'hFF};
    vecs[15] = '{1'b1, 1'b1, BASE + 32'h04, 32'h1234_5600, 1'b1, 1'b0, 32'h0, 8'h00, 8'hFF};
    vecs[16] = '{1'b1, 1'b0, BASE + 32'h14, 32'h0,         1'b1, 1'b0, 32'h0, 8'h00, 8'hFF};
  end

  initial begin
    logic [31:0] rd;
    logic ak, er;

    // Reset with a pin held high and a request pending in the reset cycle.
    rst          = 1'b0;
    gpio_port_in = 8'h02;
    mmio_req     = 1'b1;
    mmio_we      = 1'b1;
    mmio_addr    = BASE + 32'h08;
    mmio_wdata   = 32'hFF;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {13'd0, mmio_ack, mmio_err, mmio_rdata, gpio_port_out, gpio_oe, gpio_irq},
        64'd0);
    rst      = 1'b1;
    mmio_req = 1'b0;
    mmio_we  = 1'b0;
    @(negedge clk);
    chk("no_ack_after_reset", {62'd0, mmio_ack, 1'b0}, 64'd0);
    chk("dir_after_reset", {56'd0, gpio_oe}, 64'd0);
    repeat (5) @(negedge clk);
    rd_chk("data_in_sync", 6'h00, 32'h02);
    rd_chk("no_edge_high_at_release", 6'h14, 32'h00);
    gpio_port_in = 8'h00;
    repeat (4) @(negedge clk);
    rd_chk("fall_ignored_rising_cfg", 6'h14, 32'h00);

    // Back-to-back table: drive vector i while checking the response to vector i-1.
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) begin
        chk($sformatf("vec%0d", i - 1),
            {14'd0, mmio_ack, mmio_err, mmio_rdata, gpio_port_out, gpio_oe},
            {14'd0, vecs[i-1].ack, vecs[i-1].err, vecs[i-1].rdata, vecs[i-1].out, vecs[i-1].oe});
      end
      if (i < NV) begin
        mmio_req   = vecs[i].req;
        mmio_we    = vecs[i].we;
        mmio_addr  = vecs[i].addr;
        mmio_wdata = vecs[i].wdata;
      end else begin
        mmio_req = 1'b0;
        mmio_we  = 1'b0;
      end
      @(negedge clk);
    end

    // Rising edge on pin0 through to interrupt and W1C.
    wr_chk("wr_irq_en", 6'h0C, 32'h01);
    wr_chk("wr_irq_edge_rise", 6'h10, 32'h00);
    gpio_port_in = 8'h01;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("irq_not_yet", {63'd0, gpio_irq}, 64'd0);
    @(negedge clk);
    chk("irq_asserted", {63'd0, gpio_irq}, 64'd1);
    rd_chk("status_rise", 6'h14, 32'h01);
    access(1'b1, BASE + 32'h14, 32'h01, rd, ak, er);
    chk("w1c_ack_irq_held", {61'd0, ak, er, gpio_irq}, {61'd0, 1'b1, 1'b0, 1'b1});
    @(negedge clk);
    chk("irq_dropped", {63'd0, gpio_irq}, 64'd0);

    // Switching edge polarity alone must not set status.
    wr_chk("wr_irq_edge_fall", 6'h10, 32'h01);
    repeat (2) @(negedge clk);
    rd_chk("edge_cfg_no_status", 6'h14, 32'h00);

    // Falling edge reaches status on the same edge as a W1C of that bit.
    gpio_port_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    wr_chk("w1c_collide", 6'h14, 32'h01);
    rd_chk("set_wins_over_w1c", 6'h14, 32'h01);
    chk("irq_after_collide", {63'd0, gpio_irq}, 64'd1);

    // Reset for one cycle in the middle of a write burst.
    mmio_req = 1'b1; mmio_we = 1'b1; mmio_addr = BASE + 32'h04; mmio_wdata = 32'h11;
    @(negedge clk);
    chk("burst_ack0", {62'd0, mmio_ack, mmio_err}, {62'd0, 1'b1, 1'b0});
    chk("burst_out0", {56'd0, gpio_port_out}, {56'd0, 8'h11});
    rst = 1'b0; mmio_addr = BASE + 32'h08; mmio_wdata = 32'h22;
    @(negedge clk);
    chk("burst_in_reset", {13'd0, mmio_ack, mmio_err, mmio_rdata, gpio_port_out, gpio_oe, gpio_irq},
        64'd0);
    rst = 1'b1; mmio_addr = BASE + 32'h0C; mmio_wdata = 32'h0F;
    @(negedge clk);
    mmio_req = 1'b0; mmio_we = 1'b0;
    chk("burst_after_reset_ack", {62'd0, mmio_ack, mmio_err}, {62'd0, 1'b1, 1'b0});
    chk("burst_dir_cleared", {56'd0, gpio_oe}, 64'd0);
    rd_chk("rb_irq_en_new", 6'h0C, 32'h0F);
    rd_chk("rb_irq_edge_clr", 6'h10, 32'h00);
    rd_chk("rb_status_clr", 6'h14, 32'h00);
    rd_chk("rb_data_out_clr", 6'h04, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
